// File: rtl/hazard_pkg.sv
// Shared definitions for the ID/EX hazard controller: FSM state encoding,
// the hard-wired zero register specifier and the perf-counter width default.
package hazard_pkg;

    // RUN: normal flow; LD_STALL: extra load-use stall cycles beyond the first
    typedef enum logic {
        RUN      = 1'b0,
        LD_STALL = 1'b1
    } hazState_t;

    // Register $0 never carries a real dependency
    localparam int REG_ZERO = 0;

    localparam int HAZ_CNT_W_DEFAULT = 32;

endpackage

// File: rtl/hazard_event_counter.sv
// Saturating event counter used for hazard performance statistics.
// Clears synchronously; holds at all-ones once reached instead of wrapping.
module hazard_event_counter #(
    parameter int CNT_W = 32
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count events, saturating at the maximum value
    always_ff @(posedge Clock) begin
        if (clear)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX hazard controller: load-use detection, multi-cycle load stalls,
// jump flush and taken-branch flush sequencing.
// Optional feature macro: HAZ_PERF_CNT_EN (stall/flush performance counters).
// All control outputs are combinational from the registered FSM state plus
// the current inputs; only the state and stall counter are registered.
module id_ex_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = HAZ_CNT_W_DEFAULT
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [REG_ADDR_W-1:0] IFID_rs,
    input  logic [REG_ADDR_W-1:0] IFID_rt,
    input  logic                  IFID_UsesRs,
    input  logic                  IFID_UsesRt,
    input  logic                  IFID_Jump,
    input  logic                  IDEX_R_Enable,
    input  logic                  IDEX_RegWrite,
    input  logic [REG_ADDR_W-1:0] IDEX_rt,
    input  logic                  EXMEM_BrTaken,
    output logic                  PCWrite,
    output logic                  IFID_Write,
    output logic                  IFID_Flush,
    output logic                  IDEX_Bubble,
    output logic                  IDEX_Flush,
    output logic                  EXMEM_Flush,
    output logic [CNT_W-1:0]      StallCount,
    output logic [CNT_W-1:0]      FlushCount
);

    hazState_t  state;
    logic [1:0] stallLeft;   // remaining LD_STALL cycles, 1 means last
    logic       loadUse;

    // Load in EX whose destination is read by the instruction in ID
    assign loadUse = IDEX_R_Enable & IDEX_RegWrite
                   & (IDEX_rt != REG_ADDR_W'(REG_ZERO))
                   & ((IFID_UsesRs & (IDEX_rt == IFID_rs))
                    | (IFID_UsesRt & (IDEX_rt == IFID_rt)));

    // Control outputs: reset, then branch flush, then stall, then jump flush
    always_comb begin
        PCWrite     = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        IDEX_Flush  = 1'b0;
        EXMEM_Flush = 1'b0;
        if (Reset) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
            IDEX_Flush  = 1'b1;
            EXMEM_Flush = 1'b1;
        end else if (EXMEM_BrTaken) begin
            // A taken branch overrides any stall and any pending jump
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            EXMEM_Flush = 1'b1;
        end else if ((state == LD_STALL) || loadUse) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
        end else if (IFID_Jump) begin
            // Jump held by a stall falls through to here once released
            IFID_Flush  = 1'b1;
        end
    end

    // Stall sequencer: enters LD_STALL only when more than one stall cycle is needed
    always_ff @(posedge Clock) begin
        if (Reset || EXMEM_BrTaken) begin
            state     <= RUN;
            stallLeft <= 2'd0;
        end else begin
            case (state)
                RUN: begin
                    if (loadUse && (LOAD_STALL_CYCLES > 1)) begin
                        state     <= LD_STALL;
                        stallLeft <= 2'(LOAD_STALL_CYCLES - 1);
                    end
                end
                LD_STALL: begin
                    if (stallLeft == 2'd1) begin
                        state     <= RUN;
                        stallLeft <= 2'd0;
                    end else begin
                        stallLeft <= stallLeft - 2'd1;
                    end
                end
                default: begin
                    state     <= RUN;
                    stallLeft <= 2'd0;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic anyFlush;

    assign anyFlush = IFID_Flush | IDEX_Flush | EXMEM_Flush;

    // Reset clears both counters, so reset cycles are never counted
    hazard_event_counter #(.CNT_W(CNT_W)) uStallCnt (
        .Clock (Clock),
        .clear (Reset),
        .inc   (~PCWrite),
        .count (StallCount)
    );

    hazard_event_counter #(.CNT_W(CNT_W)) uFlushCnt (
        .Clock (Clock),
        .clear (Reset),
        .inc   (anyFlush),
        .count (FlushCount)
    );
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule
